// File: rtl/mmio_bus_ctrl.sv
// Registered MMIO interconnect: decodes one CPU request onto one of NUM_SLAVES regions.
// Latency: zero-wait slave acks two cycles after req; unmapped address acks one cycle after req.
// Backpressure: per-slave s_rdy stretches ACCESS, bounded by TIMEOUT_CYCLES (0 disables the bound).
module mmio_bus_ctrl #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
    parameter int TIMEOUT_CYCLES = 16,
    localparam int BE_W          = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    input  logic                             m_we,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [BE_W-1:0]                  m_be,
    output logic                             m_ack,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [BE_W-1:0]                  s_be,
    input  logic [NUM_SLAVES-1:0]            s_rdy,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    output logic                             busy,
    output logic [7:0]                       err_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic [NUM_SLAVES-1:0]   dec_hit;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    rdy_hit;
    logic                    timeout_hit;
    logic [31:0]             cnt;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    // Address decode; iterating downward leaves the lowest matching index as the winner.
    always_comb begin
        dec_hit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit    = '0;
                dec_hit[i] = 1'b1;
            end
        end
    end

    // Read-data mux and ready qualified by the current one-hot select.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        rdy_hit     = |(s_rdy & s_sel);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_req) state_nxt = (|dec_hit) ? ACCESS : RESP;
            ACCESS:  if (rdy_hit || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latching, wait-state counting, response capture and error accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_sel      <= '0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_be       <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we       <= m_we;
                        s_addr     <= m_addr;
                        s_wdata    <= m_wdata;
                        s_be       <= m_be;
                        s_sel      <= dec_hit;
                        resp_rdata <= '0;
                        resp_err   <= ~(|dec_hit);
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 32'd1;
                    if (rdy_hit) begin
                        // A ready arriving on the timeout cycle still completes cleanly.
                        s_sel      <= '0;
                        resp_rdata <= s_we ? '0 : sel_rdata;
                        resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        s_sel      <= '0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    cnt <= '0;
                    if (resp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Response outputs are gated so they read as zero outside the ack cycle.
    always_comb begin
        m_ack   = (state == RESP);
        m_rdata = m_ack ? resp_rdata : '0;
        m_err   = m_ack & resp_err;
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized bench for mmio_bus_ctrl with a transaction-level reference model.
// Latency: model predicts ack cycle, data, error and select duration per transaction.
// Backpressure: bench slaves assert ready after a chosen number of wait states.
module tb_mmio_bus_ctrl;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_req, m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic [BW-1:0]    m_be;
    logic             m_ack, m_err, s_we, busy;
    logic [DW-1:0]    m_rdata, s_wdata;
    logic [NS-1:0]    s_sel, s_rdy;
    logic [AW-1:0]    s_addr;
    logic [BW-1:0]    s_be;
    logic [NS*DW-1:0] s_rdata;
    logic [7:0]       err_count;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ecnt = 0;

    mmio_bus_ctrl dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata),
        .m_err(m_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_be(s_be), .s_rdy(s_rdy), .s_rdata(s_rdata),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // One transaction; starts and ends at posedge+1 with the DUT idle.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int lat, input logic [31:0] rd);
        int          tgt;
        logic [3:0]  oh;
        int          exp_cyc, exp_sel;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          sel_cnt = 0;
        int          cyc = 0;
        int          ack_cyc = -1;
        bit          acked = 0;
        logic [31:0] got_rd = '0;
        logic        got_err = 1'b0;

        // Reference: region = top nibble; regions 0..NS-1 are mapped.
        tgt = int'(addr[31:28]);
        oh  = (tgt < NS) ? 4'(1 << tgt) : 4'b0;
        if (oh == 4'b0) begin
            exp_cyc = 1; exp_err = 1'b1; exp_rd = '0; exp_sel = 0;
        end else if (lat < TO) begin
            exp_cyc = lat + 2; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd; exp_sel = lat + 1;
        end else begin
            exp_cyc = TO + 1; exp_err = 1'b1; exp_rd = '0; exp_sel = TO;
        end

        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_be = be;
        while (!acked && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            // Scramble master inputs so only the latched copy can be correct.
            m_req = 1'b0; m_we = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_be = 4'($urandom);
            if (s_sel != 4'b0) begin
                sel_cnt++;
                chk("s_sel", 64'(s_sel), 64'(oh));
                chk("s_addr", 64'(s_addr), 64'(addr));
                chk("s_wdata", 64'(s_wdata), 64'(wd));
                chk("s_be", 64'(s_be), 64'(be));
                chk("s_we", 64'(s_we), 64'(we));
            end
            if (m_ack) begin
                acked = 1; ack_cyc = cyc; got_rd = m_rdata; got_err = m_err;
            end else begin
                chk("quiet_resp", {31'b0, m_err, m_rdata}, 64'h0);
            end
            s_rdy = 4'($urandom) & ~oh;
            if (oh != 4'b0 && s_sel == oh && sel_cnt == lat + 1) s_rdy = s_rdy | oh;
            for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
            if (tgt < NS) s_rdata[tgt*DW +: DW] = rd;
        end
        chk("ack_seen", 64'(acked), 64'h1);
        chk("ack_cycle", 64'(ack_cyc), 64'(exp_cyc));
        chk("ack_rdata", 64'(got_rd), 64'(exp_rd));
        chk("ack_err", 64'(got_err), 64'(exp_err));
        chk("sel_cycles", 64'(sel_cnt), 64'(exp_sel));
        if (exp_err && exp_ecnt < 255) exp_ecnt++;
        @(posedge clk); #1;
        s_rdy = '0;
        chk("ack_once", 64'(m_ack), 64'h0);
        chk("busy_after", 64'(busy), 64'h0);
        chk("err_count", 64'(err_count), 64'(exp_ecnt));
    endtask

    initial begin
        rst = 1'b1; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        s_rdy = '0; s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 64'(m_ack), 64'h0);
        chk("rst_sel", 64'(s_sel), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ecnt", 64'(err_count), 64'h0);
        chk("rst_saddr", 64'(s_addr), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, 32'h1000_0010, 32'h0, 4'hF, 0, 32'hCAFE_BABE);
        do_txn(1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 3, 32'hDEAD_0001);
        do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h0);
        do_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, TO - 1, 32'h5A5A_A5A5);
        for (int k = 0; k < 300; k++) do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 20, 32'h1);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = $urandom;
            a[31:28] = 4'($urandom_range(0, 5));
            do_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 18)), $urandom);
        end

        // Asynchronous reset in the middle of an access to slave 0.
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100; s_rdy = '0;
        @(posedge clk); #1;
        m_req = 1'b0;
        chk("pre_rst_sel", 64'(s_sel), 64'h1);
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", 64'(s_sel), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_ack", 64'(m_ack), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ecnt = 0;
        @(posedge clk); #1;
        chk("post_rst_ack", 64'(m_ack), 64'h0);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_ecnt", 64'(err_count), 64'h0);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
